// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and branch-counter helpers for the IF-stage PC generator.
//   XLEN_DEF       default PC/address width
//   RESET_VEC_DEF  default PC after reset
//   FLUSH_VEC_DEF  default PC after a trap flush
//   ctr_t          2-bit saturating direction counter (SNT, WNT, WT, ST)
//   next_ctr       saturating increment on taken, saturating decrement on not-taken
package pc_pkg;

   localparam int unsigned XLEN_DEF      = 32;
   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] FLUSH_VEC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   function automatic ctr_t next_ctr(input ctr_t ctr, input logic taken);
      ctr_t res;
      res = ctr;
      if (taken) begin
         if (ctr != ST) res = ctr_t'(ctr + 2'd1);
      end else begin
         if (ctr != SNT) res = ctr_t'(ctr - 2'd1);
      end
      return res;
   endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// pc_fetch_gen_if: pipeline-side bus of the fetch PC generator.
//   Control from hazard unit / EX: stall_f, flush_f, redirect_en, redirect_pc
//   BTB training from EX:          btb_upd_en, btb_upd_pc, btb_upd_taken, btb_upd_tgt
//   Fetch outputs:                 pc_f, pred_taken_f, pred_tgt_f
// master = pipeline side, slave = pc_fetch_gen.
interface pc_fetch_gen_if
   import pc_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
);
   logic            stall_f;
   logic            flush_f;
   logic            redirect_en;
   logic [XLEN-1:0] redirect_pc;
   logic            btb_upd_en;
   logic [XLEN-1:0] btb_upd_pc;
   logic            btb_upd_taken;
   logic [XLEN-1:0] btb_upd_tgt;
   logic [XLEN-1:0] pc_f;
   logic            pred_taken_f;
   logic [XLEN-1:0] pred_tgt_f;

   modport master (
      output stall_f, flush_f, redirect_en, redirect_pc,
      output btb_upd_en, btb_upd_pc, btb_upd_taken, btb_upd_tgt,
      input  pc_f, pred_taken_f, pred_tgt_f
   );

   modport slave (
      input  stall_f, flush_f, redirect_en, redirect_pc,
      input  btb_upd_en, btb_upd_pc, btb_upd_taken, btb_upd_tgt,
      output pc_f, pred_taken_f, pred_tgt_f
   );

endinterface

// File: rtl/pc_btb.sv
// pc_btb: direct-mapped branch target buffer with 2-bit direction counters.
//   clk, rst        rising-edge clock, synchronous active-high reset (clears valid bits)
//   lkp_pc          fetch PC, looked up combinationally
//   pred_taken      hit and counter in a taken state
//   pred_tgt        stored target on a hit, zero on a miss
//   upd_en/_pc/_taken/_tgt  training strobe from EX, applied at the clock edge
module pc_btb
   import pc_pkg::*;
#(
   parameter int unsigned XLEN        = XLEN_DEF,
   parameter int unsigned BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] lkp_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_tgt,
   input  logic            upd_en,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_tgt
);

   localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
   localparam int unsigned TAGW = XLEN - IDX - 2;

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAGW-1:0]        tag_q [BTB_ENTRIES];
   logic [XLEN-3:0]        tgt_q [BTB_ENTRIES];
   ctr_t                   ctr_q [BTB_ENTRIES];

   logic [IDX-1:0]  lkp_idx;
   logic [TAGW-1:0] lkp_tag;
   logic            lkp_hit;
   ctr_t            lkp_ctr;
   logic [IDX-1:0]  upd_idx;
   logic [TAGW-1:0] upd_tag;
   logic            upd_hit;

   // Word-aligned PCs: the low two bits never reach the tables.
   logic [5:0] unused_low_bits;
   assign unused_low_bits = {lkp_pc[1:0], upd_pc[1:0], upd_tgt[1:0]};

   assign lkp_idx = lkp_pc[IDX+1:2];
   assign lkp_tag = lkp_pc[XLEN-1:IDX+2];
   assign lkp_hit = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
   assign lkp_ctr = ctr_q[lkp_idx];

   assign pred_taken = lkp_hit && ((lkp_ctr == WT) || (lkp_ctr == ST));
   assign pred_tgt   = lkp_hit ? {tgt_q[lkp_idx], 2'b00} : '0;

   assign upd_idx = upd_pc[IDX+1:2];
   assign upd_tag = upd_pc[XLEN-1:IDX+2];
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   // Lookup is combinational from the registered tables, so a same-index
   // update is only seen by the fetch in the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (upd_en) begin
         if (upd_hit) begin
            ctr_q[upd_idx] <= next_ctr(ctr_q[upd_idx], upd_taken);
            if (upd_taken) tgt_q[upd_idx] <= upd_tgt[XLEN-1:2];
         end else if (upd_taken) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= upd_tgt[XLEN-1:2];
            ctr_q[upd_idx]   <= WT;
         end
      end
   end

endmodule

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: IF-stage program counter with next-PC selection and optional BTB.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, loads RESET_VEC
//   bus   pc_fetch_gen_if.slave: stall/flush/redirect control, BTB training,
//         fetch PC (imem address) and the prediction forwarded down the pipe
// Next-PC priority: rst > flush_f > redirect_en > stall_f > prediction > pc_f+4.
module pc_fetch_gen
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN        = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(RESET_VEC_DEF),
   parameter logic [XLEN-1:0] FLUSH_VEC   = XLEN'(FLUSH_VEC_DEF),
   parameter int unsigned     BTB_ENTRIES = 16,
   parameter bit              BTB_EN      = 1'b1
) (
   input logic           clk,
   input logic           rst,
   pc_fetch_gen_if.slave bus
);

   localparam logic [XLEN-1:0] RESET_PC = {RESET_VEC[XLEN-1:2], 2'b00};
   localparam logic [XLEN-1:0] FLUSH_PC = {FLUSH_VEC[XLEN-1:2], 2'b00};

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_next;
   logic            pred_taken;
   logic [XLEN-1:0] pred_tgt;

   generate
      if (BTB_EN) begin : g_btb
         pc_btb #(
            .XLEN        (XLEN),
            .BTB_ENTRIES (BTB_ENTRIES)
         ) u_btb (
            .clk        (clk),
            .rst        (rst),
            .lkp_pc     (pc_q),
            .pred_taken (pred_taken),
            .pred_tgt   (pred_tgt),
            .upd_en     (bus.btb_upd_en),
            .upd_pc     (bus.btb_upd_pc),
            .upd_taken  (bus.btb_upd_taken),
            .upd_tgt    (bus.btb_upd_tgt)
         );
      end else begin : g_no_btb
         logic unused_upd;
         assign unused_upd = ^{bus.btb_upd_en, bus.btb_upd_pc, bus.btb_upd_taken, bus.btb_upd_tgt};
         assign pred_taken = 1'b0;
         assign pred_tgt   = '0;
      end
   endgenerate

   // Low bits of the redirect target are dropped so pc_f stays word aligned.
   always_comb begin
      pc_next = pc_q + XLEN'(4);
      if (bus.flush_f) begin
         pc_next = FLUSH_PC;
      end else if (bus.redirect_en) begin
         pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else if (bus.stall_f) begin
         pc_next = pc_q;
      end else if (pred_taken) begin
         pc_next = pred_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_next;
   end

   assign bus.pc_f         = pc_q;
   assign bus.pred_taken_f = pred_taken;
   assign bus.pred_tgt_f   = pred_tgt;

endmodule

// File: tb/tb_pc_fetch_gen.sv
module tb_pc_fetch_gen;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] FVEC = 32'h0000_01C0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_fetch_gen_if #(.XLEN(XLEN)) bus ();

   pc_fetch_gen #(
      .XLEN        (XLEN),
      .RESET_VEC   (32'h0),
      .FLUSH_VEC   (FVEC),
      .BTB_ENTRIES (16),
      .BTB_EN      (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: BTB as plain arrays indexed by (pc/4)%16, tag pc/64.
   logic [31:0] m_pc = 32'h0;
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   logic [31:0] m_nxt;
   int          m_k;

   function automatic int ix(input logic [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[ix(pc)] && (m_tag[ix(pc)] == pc / 64);
   endfunction

   function automatic bit m_ptaken(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[ix(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
      return m_hit(pc) ? m_tgt[ix(pc)] : 32'h0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_pc = 32'h0;
         for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else begin
         if (bus.flush_f)            m_nxt = FVEC;
         else if (bus.redirect_en)   m_nxt = bus.redirect_pc & ~32'h3;
         else if (bus.stall_f)       m_nxt = m_pc;
         else if (m_ptaken(m_pc))    m_nxt = m_ptgt(m_pc);
         else                        m_nxt = m_pc + 32'd4;
         if (bus.btb_upd_en) begin
            m_k = ix(bus.btb_upd_pc);
            if (m_hit(bus.btb_upd_pc)) begin
               if (bus.btb_upd_taken) begin
                  m_ctr[m_k] = (m_ctr[m_k] < 3) ? m_ctr[m_k] + 1 : 3;
                  m_tgt[m_k] = bus.btb_upd_tgt & ~32'h3;
               end else begin
                  m_ctr[m_k] = (m_ctr[m_k] > 0) ? m_ctr[m_k] - 1 : 0;
               end
            end else if (bus.btb_upd_taken) begin
               m_valid[m_k] = 1'b1;
               m_tag[m_k]   = bus.btb_upd_pc / 64;
               m_tgt[m_k]   = bus.btb_upd_tgt & ~32'h3;
               m_ctr[m_k]   = 2;
            end
         end
         m_pc = m_nxt;
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         check("model pc_f", bus.pc_f, m_pc);
         check("model pred_taken_f", 32'(bus.pred_taken_f), 32'(m_ptaken(m_pc)));
         check("model pred_tgt_f", bus.pred_tgt_f, m_ptgt(m_pc));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic [31:0] a);
      bus.redirect_en = 1'b1;
      bus.redirect_pc = a;
      step();
      bus.redirect_en = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      bus.btb_upd_en    = 1'b1;
      bus.btb_upd_pc    = pc;
      bus.btb_upd_taken = taken;
      bus.btb_upd_tgt   = tgt;
   endtask

   initial begin
      bus.stall_f       = 1'b0;
      bus.flush_f       = 1'b0;
      bus.redirect_en   = 1'b0;
      bus.redirect_pc   = 32'h0;
      bus.btb_upd_en    = 1'b0;
      bus.btb_upd_pc    = 32'h0;
      bus.btb_upd_taken = 1'b0;
      bus.btb_upd_tgt   = 32'h0;
      rst = 1'b1;

      // reset sequence and free-running PC+4
      step();
      chk_en = 1'b1;
      check("reset pc 1", bus.pc_f, 32'h0);
      check("reset pred", 32'(bus.pred_taken_f), 32'h0);
      step();
      check("reset pc 2", bus.pc_f, 32'h0);
      rst = 1'b0;
      step(); check("seq 0x4", bus.pc_f, 32'h4);
      step(); check("seq 0x8", bus.pc_f, 32'h8);
      step(); check("seq 0xC", bus.pc_f, 32'hC);
      step(); check("seq 0x10", bus.pc_f, 32'h10);

      // stall hold, then stall overridden by redirect
      bus.stall_f = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall hold", bus.pc_f, 32'h10);
      end
      bus.stall_f = 1'b0;
      step(); check("after stall", bus.pc_f, 32'h14);
      bus.stall_f = 1'b1;
      step(); check("stall 2 hold", bus.pc_f, 32'h14);
      redir(32'h203);
      check("redirect over stall", bus.pc_f, 32'h200);
      step(); check("stall after redirect", bus.pc_f, 32'h200);
      bus.stall_f = 1'b0;
      step(); check("resume 0x204", bus.pc_f, 32'h204);

      // flush wins over redirect
      bus.flush_f = 1'b1;
      redir(32'h80);
      bus.flush_f = 1'b0;
      check("flush over redirect", bus.pc_f, 32'h1C0);
      step(); check("after flush", bus.pc_f, 32'h1C4);

      // train 0x40 taken, then predict
      upd(32'h40, 1'b1, 32'h100);
      step();
      bus.btb_upd_en = 1'b0;
      redir(32'h40);
      check("pred hit taken", 32'(bus.pred_taken_f), 32'h1);
      check("pred tgt 0x100", bus.pred_tgt_f, 32'h100);
      step(); check("follow prediction", bus.pc_f, 32'h100);

      // two not-taken updates: WT -> WNT -> SNT
      upd(32'h40, 1'b0, 32'h0);
      step(); step();
      bus.btb_upd_en = 1'b0;
      redir(32'h40);
      check("weakened pred", 32'(bus.pred_taken_f), 32'h0);
      step(); check("fallthrough 0x44", bus.pc_f, 32'h44);

      // aliasing: 0x80 shares index 0 with 0x40 and replaces it
      upd(32'h40, 1'b1, 32'h100);
      step();
      upd(32'h80, 1'b1, 32'h300);
      step();
      bus.btb_upd_en = 1'b0;
      redir(32'h40);
      check("alias miss pred", 32'(bus.pred_taken_f), 32'h0);
      check("alias miss tgt", bus.pred_tgt_f, 32'h0);
      step(); check("alias fallthrough", bus.pc_f, 32'h44);
      redir(32'h80);
      check("0x80 hit", 32'(bus.pred_taken_f), 32'h1);
      check("0x80 tgt", bus.pred_tgt_f, 32'h300);
      step(); check("0x80 follow", bus.pc_f, 32'h300);

      // saturation: WT +2 taken -> ST (saturated), -1 -> WT, -1 -> WNT
      upd(32'h80, 1'b1, 32'h300);
      step(); step();
      bus.btb_upd_taken = 1'b0;
      step();
      bus.btb_upd_en = 1'b0;
      redir(32'h80);
      check("sat then dec still taken", 32'(bus.pred_taken_f), 32'h1);
      upd(32'h80, 1'b0, 32'h0);
      step();
      bus.btb_upd_en = 1'b0;
      redir(32'h80);
      check("second dec not taken", 32'(bus.pred_taken_f), 32'h0);

      // update coincident with lookup of the same entry
      redir(32'h40);
      upd(32'h40, 1'b1, 32'h143);
      check("coincident old pred", 32'(bus.pred_taken_f), 32'h0);
      step();
      bus.btb_upd_en = 1'b0;
      check("coincident old path", bus.pc_f, 32'h44);
      redir(32'h40);
      check("new entry pred", 32'(bus.pred_taken_f), 32'h1);
      check("new entry tgt aligned", bus.pred_tgt_f, 32'h140);

      // PC+4 wrap
      redir(32'hFFFF_FFFC);
      check("wrap start", bus.pc_f, 32'hFFFF_FFFC);
      step(); check("wrap to 0", bus.pc_f, 32'h0);

      // reset during a training strobe discards the update
      rst = 1'b1;
      upd(32'h40, 1'b1, 32'h180);
      step();
      rst = 1'b0;
      bus.btb_upd_en = 1'b0;
      check("mid reset pc", bus.pc_f, 32'h0);
      redir(32'h40);
      check("discarded update pred", 32'(bus.pred_taken_f), 32'h0);
      check("discarded update tgt", bus.pred_tgt_f, 32'h0);
      step(); check("discarded fallthrough", bus.pc_f, 32'h44);

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
